// File: rtl/x9_pkg.sv
// Shared X9 fetch definitions: FSM states, HALT opcode, NOP word and the
// absolute branch-target table that the assembler also uses.
package x9_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fetch_state_t;

  localparam logic [4:0] OP_HALT   = 5'b11111;
  localparam logic [8:0] NOP_INSTR = 9'b0;

  localparam int LUT_PC_W = 10;
  typedef logic [LUT_PC_W-1:0] lut_entry_t;

  // Entry 0 is reserved and always targets address 0.
  localparam lut_entry_t BRANCH_LUT [16] = '{
    10'd0,   10'd16,  10'd40,  10'd48,
    10'd64,  10'd80,  10'd96,  10'd112,
    10'd128, 10'd144, 10'd160, 10'd176,
    10'd192, 10'd208, 10'd224, 10'd240
  };

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus between the fetch unit (master) and the core/harness (slave).
// Perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_unit_if #(
  parameter int PCWIDTH = 10,
  parameter int IWIDTH  = 9
);
  // Start is a single-cycle pulse with no ready; it is only acted on in IDLE
  // or HALT. ImemData must be valid combinationally for the current ImemAddr.
  logic               Start;
  logic               Stall;
  logic               BranchTaken;
  logic [IWIDTH-1:0]  ImemData;
  logic [PCWIDTH-1:0] ImemAddr;
  logic [IWIDTH-1:0]  Instr;
  logic [PCWIDTH-1:0] InstrPC;
  logic               Valid;
  logic               Done;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0]        CycleCount;
  logic [7:0]         BubbleCount;
`endif

  modport master (
    input  Start, Stall, BranchTaken, ImemData,
    output ImemAddr, Instr, InstrPC, Valid, Done
`ifdef FETCH_PERF_CNT_EN
    , output CycleCount, BubbleCount
`endif
  );

  modport slave (
    output Start, Stall, BranchTaken, ImemData,
    input  ImemAddr, Instr, InstrPC, Valid, Done
`ifdef FETCH_PERF_CNT_EN
    , input CycleCount, BubbleCount
`endif
  );
endinterface

// File: rtl/branch_lut.sv
// Combinational branch-target lookup; contents are the fixed package table.
module branch_lut
  import x9_pkg::*;
#(
  parameter int PCWIDTH = 10,
  parameter int LUTBITS = 4
) (
  input  logic [LUTBITS-1:0] idx,
  output logic [PCWIDTH-1:0] target
);

  lut_entry_t entry;

  assign entry  = BRANCH_LUT[idx];
  assign target = entry[PCWIDTH-1:0];

endmodule

// File: rtl/fetch_unit.sv
// X9 instruction fetch: PC/IR sequencing, branch redirect with one bubble,
// HALT detection and Start/Done. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_unit
  import x9_pkg::*;
#(
  parameter int PCWIDTH   = 10,
  parameter int IWIDTH    = 9,
  parameter int MCODEBITS = 5,
  parameter int LUTBITS   = 4
) (
  input  logic         Clk,
  input  logic         Reset_n,
  fetch_unit_if.master bus,
  output fetch_state_t fsm_state
);

  fetch_state_t       state;
  logic [PCWIDTH-1:0] pc;
  logic [IWIDTH-1:0]  instr;
  logic [PCWIDTH-1:0] instr_pc;
  logic               valid;
  logic               done;
  logic [PCWIDTH-1:0] target;
  logic               is_halt;
  logic               redirect;

  branch_lut #(.PCWIDTH(PCWIDTH), .LUTBITS(LUTBITS)) u_lut (
    .idx    (instr[LUTBITS-1:0]),
    .target (target)
  );

  // HALT outranks a taken branch, so a HALT word can never redirect.
  assign is_halt  = valid && (instr[IWIDTH-1 -: MCODEBITS] == OP_HALT);
  assign redirect = valid && bus.BranchTaken && !is_halt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      pc       <= '0;
      instr    <= NOP_INSTR;
      instr_pc <= '0;
      valid    <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pc    <= '0;
          valid <= 1'b0;
          if (bus.Start) state <= FILL;
        end
        FILL: begin
          instr    <= bus.ImemData;
          instr_pc <= pc;
          pc       <= pc + 1'b1;
          valid    <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          if (is_halt) begin
            state <= HALT;
            done  <= 1'b1;
            valid <= 1'b0;
          end else if (redirect) begin
            pc    <= target;
            instr <= NOP_INSTR;
            valid <= 1'b0;
          end else if (!bus.Stall) begin
            instr    <= bus.ImemData;
            instr_pc <= pc;
            pc       <= pc + 1'b1;
            valid    <= 1'b1;
          end
        end
        HALT: begin
          if (bus.Start) begin
            pc    <= '0;
            done  <= 1'b0;
            state <= FILL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ImemAddr = pc;
  assign bus.Instr    = instr;
  assign bus.InstrPC  = instr_pc;
  assign bus.Valid    = valid;
  assign bus.Done     = done;
  assign fsm_state    = state;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cycle_cnt;
  logic [7:0]  bubble_cnt;
  logic        start_ok;

  assign start_ok = bus.Start && ((state == IDLE) || (state == HALT));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cycle_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (start_ok) begin
      cycle_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (((state == FILL) || (state == RUN)) && (cycle_cnt != 16'hFFFF))
        cycle_cnt <= cycle_cnt + 16'd1;
      if ((state == RUN) && redirect && (bubble_cnt != 8'hFF))
        bubble_cnt <= bubble_cnt + 8'd1;
    end
  end

  assign bus.CycleCount  = cycle_cnt;
  assign bus.BubbleCount = bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, straight-line, branch, stall, wrap
// (second instance with PCWIDTH=4), restart and mid-run reset.
module tb_fetch_unit;
  import x9_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [8:0] mem  [1024];
  logic [8:0] mem2 [16];

  fetch_unit_if #(.PCWIDTH(10), .IWIDTH(9)) bus ();
  fetch_unit_if #(.PCWIDTH(4),  .IWIDTH(9)) bus2 ();
  fetch_state_t st;
  fetch_state_t st2;

  fetch_unit #(.PCWIDTH(10)) dut (
    .Clk(clk), .Reset_n(rst_n), .bus(bus.master), .fsm_state(st)
  );

  fetch_unit #(.PCWIDTH(4)) dut_w (
    .Clk(clk), .Reset_n(rst_n), .bus(bus2.master), .fsm_state(st2)
  );

  assign bus.ImemData  = mem[bus.ImemAddr];
  assign bus2.ImemData = mem2[bus2.ImemAddr];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
  endtask

  task automatic expect_instr(input string tag, input logic [8:0] ins, input logic [9:0] ipc);
    check({tag, "_instr"}, 32'(bus.Instr), 32'(ins));
    check({tag, "_ipc"},   32'(bus.InstrPC), 32'(ipc));
    check({tag, "_valid"}, 32'(bus.Valid), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.Start = 1'b0;  bus.Stall = 1'b0;  bus.BranchTaken = 1'b0;
    bus2.Start = 1'b0; bus2.Stall = 1'b0; bus2.BranchTaken = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 9'h000;
    for (int i = 0; i < 16; i++) mem2[i] = 9'(9'h010 + i);

    #3;
    check("rst_pc",    32'(bus.ImemAddr), 32'd0);
    check("rst_instr", 32'(bus.Instr), 32'd0);
    check("rst_ipc",   32'(bus.InstrPC), 32'd0);
    check("rst_valid", 32'(bus.Valid), 32'd0);
    check("rst_done",  32'(bus.Done), 32'd0);
    check("rst_state", 32'(st), 32'(IDLE));
    step(); step();
    rst_n = 1'b1;
    step();
    check("idle_pc",    32'(bus.ImemAddr), 32'd0);
    check("idle_state", 32'(st), 32'(IDLE));

    // PC wrap on the 4-bit instance
    bus2.Start = 1'b1;
    step();
    bus2.Start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step();
      check("wrap_ipc",   32'(bus2.InstrPC), 32'(i % 16));
      check("wrap_instr", 32'(bus2.Instr), 32'(mem2[i % 16]));
      check("wrap_done",  32'(bus2.Done), 32'd0);
    end

    // straight-line program ending in HALT
    mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = 9'h1F0;
    pulse_start();
    check("fill_state", 32'(st), 32'(FILL));
    check("fill_pc",    32'(bus.ImemAddr), 32'd0);
    step(); expect_instr("a0", 9'h001, 10'd0);
    step(); expect_instr("a1", 9'h002, 10'd1);
    step(); expect_instr("a2", 9'h003, 10'd2);
    step(); expect_instr("a3", 9'h1F0, 10'd3);
    step();
    check("halt_done",  32'(bus.Done), 32'd1);
    check("halt_valid", 32'(bus.Valid), 32'd0);
    check("halt_pc",    32'(bus.ImemAddr), 32'd4);
    check("halt_state", 32'(st), 32'(HALT));
    bus.Stall = 1'b1;
    step();
    bus.Stall = 1'b0;
    check("halt_hold_pc", 32'(bus.ImemAddr), 32'd4);

    // restart, with an ignored Start during RUN
    pulse_start();
    check("rs_done", 32'(bus.Done), 32'd0);
    check("rs_pc",   32'(bus.ImemAddr), 32'd0);
    step(); expect_instr("r0", 9'h001, 10'd0);
    pulse_start();
    expect_instr("r1", 9'h002, 10'd1);
    check("r1_pc", 32'(bus.ImemAddr), 32'd2);
    step(); expect_instr("r2", 9'h003, 10'd2);
    step(); expect_instr("r3", 9'h1F0, 10'd3);
    step();
    check("r_done", 32'(bus.Done), 32'd1);
    check("r_pc",   32'(bus.ImemAddr), 32'd4);

    // taken branch, ignored branch on bubble, stall, stall+branch, HALT vs branch
    mem[1] = 9'h0A2; mem[2] = 9'h0FF; mem[40] = 9'h055; mem[41] = 9'h056; mem[80] = 9'h1F0;
    pulse_start();
    step(); expect_instr("b0", 9'h001, 10'd0);
    step(); expect_instr("b1", 9'h0A2, 10'd1);
    bus.BranchTaken = 1'b1;
    step();
    check("br_valid", 32'(bus.Valid), 32'd0);
    check("br_instr", 32'(bus.Instr), 32'd0);
    check("br_pc",    32'(bus.ImemAddr), 32'd40);
    step(); expect_instr("b40", 9'h055, 10'd40);
    check("b40_pc", 32'(bus.ImemAddr), 32'd41);
    bus.BranchTaken = 1'b0;
    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_instr("stall", 9'h055, 10'd40);
      check("stall_pc", 32'(bus.ImemAddr), 32'd41);
    end
    bus.BranchTaken = 1'b1;
    step();
    check("sb_valid", 32'(bus.Valid), 32'd0);
    check("sb_pc",    32'(bus.ImemAddr), 32'd80);
    bus.BranchTaken = 1'b0;
    bus.Stall = 1'b0;
    step(); expect_instr("b80", 9'h1F0, 10'd80);
    bus.BranchTaken = 1'b1;
    step();
    bus.BranchTaken = 1'b0;
    check("hb_done", 32'(bus.Done), 32'd1);
    check("hb_pc",   32'(bus.ImemAddr), 32'd81);

    // asynchronous reset mid-RUN at PC=7
    for (int i = 0; i < 16; i++) mem[i] = 9'(9'h100 + i);
    pulse_start();
    step();
    for (int i = 0; i < 6; i++) step();
    check("pre_rst_pc", 32'(bus.ImemAddr), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_pc",    32'(bus.ImemAddr), 32'd0);
    check("mr_instr", 32'(bus.Instr), 32'd0);
    check("mr_valid", 32'(bus.Valid), 32'd0);
    check("mr_done",  32'(bus.Done), 32'd0);
    check("mr_state", 32'(st), 32'(IDLE));
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_pc",    32'(bus.ImemAddr), 32'd0);
      check("post_valid", 32'(bus.Valid), 32'd0);
      check("post_state", 32'(st), 32'(IDLE));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
